// File: rtl/m3_phase_driver.sv
// Six-step commutation driver for the m3 bridge: high-side PWM, low side held on,
// dead time at every step change and on stop, shadowed period/power/direction.
module m3_phase_driver #(
  parameter int PERIOD_W   = 16,
  parameter int POWER_W    = 8,
  parameter int POWER_MAX  = 100,
  parameter int MIN_PERIOD = 200,
  parameter int DEAD_T     = 4
) (
  input  logic                clkI,
  input  logic                nRstI,
  input  logic                workingI,
  input  logic                m3forceStopI,
  input  logic                m3invRotateI,
  input  logic [PERIOD_W-1:0] stepPeriodI,
  input  logic [POWER_W-1:0]  powerI,
  input  logic                loadI,
  output logic [5:0]          gateO,
  output logic [2:0]          stepIdxO,
  output logic                stepTickO,
  output logic                runningO
);

  localparam int DCNT_W = (DEAD_T > 1) ? $clog2(DEAD_T) : 1;

  localparam logic [DCNT_W-1:0]   DEAD_LAST = DCNT_W'(DEAD_T - 1);
  localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] PER_ONE   = PERIOD_W'(1);
  localparam logic [POWER_W-1:0]  POW_MAX_V = POWER_W'(POWER_MAX);
  localparam logic [POWER_W-1:0]  PWM_LAST  = POWER_W'(POWER_MAX - 1);
  localparam logic [POWER_W-1:0]  PWM_ONE   = POWER_W'(1);
  localparam logic [DCNT_W-1:0]   DCNT_ONE  = DCNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEAD = 2'd1,
    S_RUN  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [PERIOD_W-1:0] step_cnt_q, step_cnt_d;
  logic [POWER_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [2:0]          step_idx_q, step_idx_d;
  logic [PERIOD_W-1:0] per_sh_q, per_sh_d;
  logic [POWER_W-1:0]  pow_sh_q, pow_sh_d;
  logic                dir_sh_q, dir_sh_d;
  logic [PERIOD_W-1:0] per_act_q, per_act_d;
  logic [POWER_W-1:0]  pow_act_q, pow_act_d;
  logic [5:0]          gate_q, gate_d;
  logic                tick_q, tick_d;
  logic                running_q, running_d;

  logic [PERIOD_W-1:0] eff_per;
  logic [POWER_W-1:0]  eff_pow;
  logic                eff_dir;

  function automatic logic [PERIOD_W-1:0] sat_period(input logic [PERIOD_W-1:0] p);
    return (p < MIN_P) ? MIN_P : p;
  endfunction

  function automatic logic [POWER_W-1:0] sat_power(input logic [POWER_W-1:0] p);
    return (p > POW_MAX_V) ? POW_MAX_V : p;
  endfunction

  function automatic logic [2:0] next_idx(input logic [2:0] idx, input logic down);
    logic [2:0] n;
    if (down) n = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
    else      n = (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
    return n;
  endfunction

  // Gate order {Ah,Al,Bh,Bl,Ch,Cl}; one phase high-side (PWM), another low-side on.
  function automatic logic [5:0] gate_decode(input logic [2:0] idx, input logic hi_on);
    logic [5:0] g;
    case (idx)
      3'd0:    g = {hi_on, 1'b0, 1'b0,  1'b1, 1'b0,  1'b0};
      3'd1:    g = {hi_on, 1'b0, 1'b0,  1'b0, 1'b0,  1'b1};
      3'd2:    g = {1'b0,  1'b0, hi_on, 1'b0, 1'b0,  1'b1};
      3'd3:    g = {1'b0,  1'b1, hi_on, 1'b0, 1'b0,  1'b0};
      3'd4:    g = {1'b0,  1'b1, 1'b0,  1'b0, hi_on, 1'b0};
      3'd5:    g = {1'b0,  1'b0, 1'b0,  1'b1, hi_on, 1'b0};
      default: g = 6'b000000;
    endcase
    return g;
  endfunction

  // A load in the same cycle as a boundary must reach the new step, so bypass the shadow.
  always_comb begin
    eff_per = loadI ? stepPeriodI  : per_sh_q;
    eff_pow = loadI ? powerI       : pow_sh_q;
    eff_dir = loadI ? m3invRotateI : dir_sh_q;
  end

  always_comb begin
    per_sh_d   = eff_per;
    pow_sh_d   = eff_pow;
    dir_sh_d   = eff_dir;
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    step_cnt_d = step_cnt_q;
    pwm_cnt_d  = pwm_cnt_q;
    step_idx_d = step_idx_q;
    per_act_d  = per_act_q;
    pow_act_d  = pow_act_q;
    tick_d     = 1'b0;

    if (m3forceStopI) begin
      state_d = S_IDLE;
      dcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (workingI) begin
            state_d   = S_DEAD;
            dcnt_d    = '0;
            per_act_d = sat_period(eff_per);
            pow_act_d = sat_power(eff_pow);
          end
        end
        S_DEAD: begin
          if (!workingI) begin
            state_d = S_STOP;
            dcnt_d  = '0;
          end else if (dcnt_q >= DEAD_LAST) begin
            state_d    = S_RUN;
            step_cnt_d = '0;
            pwm_cnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + DCNT_ONE;
          end
        end
        S_RUN: begin
          if (!workingI) begin
            state_d = S_STOP;
            dcnt_d  = '0;
          end else if (step_cnt_q >= per_act_q - PER_ONE) begin
            state_d    = S_DEAD;
            dcnt_d     = '0;
            step_cnt_d = '0;
            step_idx_d = next_idx(step_idx_q, eff_dir);
            per_act_d  = sat_period(eff_per);
            pow_act_d  = sat_power(eff_pow);
            tick_d     = 1'b1;
          end else begin
            step_cnt_d = step_cnt_q + PER_ONE;
            pwm_cnt_d  = (pwm_cnt_q >= PWM_LAST) ? '0 : pwm_cnt_q + PWM_ONE;
          end
        end
        S_STOP: begin
          if (dcnt_q >= DEAD_LAST) state_d = S_IDLE;
          else                     dcnt_d  = dcnt_q + DCNT_ONE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are derived from the next state so the registered value matches the state it accompanies.
    running_d = (state_d == S_DEAD) || (state_d == S_RUN);
    gate_d    = (state_d == S_RUN) ? gate_decode(step_idx_d, pwm_cnt_d < pow_act_d) : 6'b000000;
  end

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      state_q    <= S_IDLE;
      dcnt_q     <= '0;
      step_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      step_idx_q <= 3'd0;
      per_sh_q   <= MIN_P;
      pow_sh_q   <= '0;
      dir_sh_q   <= 1'b0;
      per_act_q  <= MIN_P;
      pow_act_q  <= '0;
      gate_q     <= 6'b000000;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      step_cnt_q <= step_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      step_idx_q <= step_idx_d;
      per_sh_q   <= per_sh_d;
      pow_sh_q   <= pow_sh_d;
      dir_sh_q   <= dir_sh_d;
      per_act_q  <= per_act_d;
      pow_act_q  <= pow_act_d;
      gate_q     <= gate_d;
      tick_q     <= tick_d;
      running_q  <= running_d;
    end
  end

  assign gateO     = gate_q;
  assign stepIdxO  = step_idx_q;
  assign stepTickO = tick_q;
  assign runningO  = running_q;

endmodule

// File: tb/tb_m3_phase_driver.sv
// Scoreboard bench for m3_phase_driver: a position-within-step reference model predicts
// every cycle's outputs and each step tick; a monitor pops and compares them.
module tb_m3_phase_driver;

  localparam int PERIOD_W   = 16;
  localparam int POWER_W    = 8;
  localparam int POWER_MAX  = 100;
  localparam int MIN_PERIOD = 200;
  localparam int DEAD_T     = 4;

  localparam int M_IDLE = 0;
  localparam int M_ON   = 1;
  localparam int M_STOP = 2;

  logic                clk = 1'b0;
  logic                nRstI = 1'b0;
  logic                workingI = 1'b0;
  logic                m3forceStopI = 1'b0;
  logic                m3invRotateI = 1'b0;
  logic [PERIOD_W-1:0] stepPeriodI = '0;
  logic [POWER_W-1:0]  powerI = '0;
  logic                loadI = 1'b0;
  logic [5:0]          gateO;
  logic [2:0]          stepIdxO;
  logic                stepTickO;
  logic                runningO;

  m3_phase_driver #(
    .PERIOD_W(PERIOD_W), .POWER_W(POWER_W), .POWER_MAX(POWER_MAX),
    .MIN_PERIOD(MIN_PERIOD), .DEAD_T(DEAD_T)
  ) dut (
    .clkI(clk), .nRstI(nRstI), .workingI(workingI), .m3forceStopI(m3forceStopI),
    .m3invRotateI(m3invRotateI), .stepPeriodI(stepPeriodI), .powerI(powerI), .loadI(loadI),
    .gateO(gateO), .stepIdxO(stepIdxO), .stepTickO(stepTickO), .runningO(runningO)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] gate;
    logic [2:0] idx;
    logic       tick;
    logic       run;
  } exp_t;

  exp_t exp_q[$];
  int   tick_q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  bit   done = 1'b0;

  // Commutation table as phase numbers (A=0, B=1, C=2).
  int hi_ph[6] = '{0, 0, 1, 1, 2, 2};
  int lo_ph[6] = '{1, 2, 2, 0, 0, 1};

  int m_sh_per = MIN_PERIOD, m_sh_pow = 0, m_sh_dir = 0;
  int m_act_per = MIN_PERIOD, m_act_pow = 0;
  int m_idx = 0, m_mode = M_IDLE, m_pos = 0, m_left = 0;

  int  w_i = 0, fs_i = 0, dir_i = 0, per_i = 0, pow_i = 0;

  task automatic take_active();
    m_act_per = (m_sh_per < MIN_PERIOD) ? MIN_PERIOD : m_sh_per;
    m_act_pow = (m_sh_pow > POWER_MAX) ? POWER_MAX : m_sh_pow;
  endtask

  // Step = DEAD_T dead cycles then period drive cycles; m_pos is the position within it.
  task automatic model_update(input bit ld);
    exp_t e;
    bit   tk;
    tk = 1'b0;
    if (ld) begin
      m_sh_per = int'(stepPeriodI);
      m_sh_pow = int'(powerI);
      m_sh_dir = int'(m3invRotateI);
    end
    if (m3forceStopI) m_mode = M_IDLE;
    else begin
      case (m_mode)
        M_IDLE: if (workingI) begin m_mode = M_ON; m_pos = 0; take_active(); end
        M_ON: begin
          if (!workingI) begin
            m_mode = M_STOP; m_left = DEAD_T - 1;
          end else if (m_pos == DEAD_T + m_act_per - 1) begin
            m_pos = 0;
            m_idx = (m_sh_dir != 0) ? (m_idx + 5) % 6 : (m_idx + 1) % 6;
            take_active();
            tk = 1'b1;
            tick_q.push_back(m_idx);
          end else m_pos++;
        end
        default: begin
          if (m_left == 0) m_mode = M_IDLE;
          else m_left--;
        end
      endcase
    end
    e.gate = 6'b000000;
    if (m_mode == M_ON && m_pos >= DEAD_T) begin
      e.gate[4 - 2 * lo_ph[m_idx]] = 1'b1;
      if (((m_pos - DEAD_T) % POWER_MAX) < m_act_pow) e.gate[5 - 2 * hi_ph[m_idx]] = 1'b1;
    end
    e.idx  = 3'(m_idx);
    e.tick = tk;
    e.run  = (m_mode == M_ON);
    exp_q.push_back(e);
  endtask

  task automatic step_cycle(input bit ld);
    workingI     = (w_i != 0);
    m3forceStopI = (fs_i != 0);
    m3invRotateI = (dir_i != 0);
    stepPeriodI  = PERIOD_W'(per_i);
    powerI       = POWER_W'(pow_i);
    loadI        = ld;
    model_update(ld);
    @(negedge clk);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step_cycle(1'b0);
  endtask

  task automatic run_until_pos(input int idx, input int pos, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (m_mode == M_ON && m_pos == pos && (idx < 0 || m_idx == idx)) break;
      step_cycle(1'b0);
    end
  endtask

  // Stimulus
  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    nRstI  = 1'b1;
    mon_en = 1'b1;

    run_n(1000);

    per_i = 300; pow_i = 50; dir_i = 0; w_i = 1;
    step_cycle(1'b1);
    run_n(6 * 304 + 50);

    run_until_pos(2, 150, 2000);
    dir_i = 1;
    step_cycle(1'b1);
    run_n(3 * 304 + 20);

    per_i = 10; pow_i = 255;
    step_cycle(1'b1);
    run_n(3 * 204 + 10);

    run_until_pos(-1, DEAD_T + 50, 1000);
    fs_i = 1;
    step_cycle(1'b0);
    fs_i = 0;
    run_n(500);

    run_until_pos(-1, DEAD_T + 80, 1000);
    w_i = 0;
    run_n(30);

    w_i = 1;
    for (int c = 0; c < 20000; c++) begin
      bit ld;
      ld = 1'b0;
      if ($urandom_range(299, 0) == 0) w_i = 1 - w_i;
      fs_i = ($urandom_range(1999, 0) == 0) ? 1 : 0;
      if ($urandom_range(149, 0) == 0) begin
        per_i = int'($urandom_range(450, 0));
        pow_i = int'($urandom_range(255, 0));
        dir_i = int'($urandom_range(1, 0));
        ld = 1'b1;
      end
      step_cycle(ld);
    end
    fs_i = 0;
    run_n(5);

    mon_en = 1'b0;
    done   = 1'b1;
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Monitor
  initial begin
    int   cyc_n;
    exp_t e, a;
    int   t;
    cyc_n = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("reset_gate", int'(gateO), 0);
      chk("reset_idx", int'(stepIdxO), 0);
      chk("reset_tick", int'(stepTickO), 0);
      chk("reset_running", int'(runningO), 0);
    end
    while (!done) begin
      @(posedge clk); #1;
      if (mon_en) begin
        cyc_n++;
        a = {gateO, stepIdxO, stepTickO, runningO};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL cycle_out: cyc=%0d no expected entry queued", cyc_n);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            bad++;
            $display("FAIL cycle_out: cyc=%0d got gate=%b idx=%0d tick=%b run=%b want gate=%b idx=%0d tick=%b run=%b",
                     cyc_n, a.gate, a.idx, a.tick, a.run, e.gate, e.idx, e.tick, e.run);
          end
        end
        chk("gate_overlap", int'((gateO[5] & gateO[4]) | (gateO[3] & gateO[2]) | (gateO[1] & gateO[0])), 0);
        if (stepTickO) begin
          if (tick_q.size() == 0) chk("tick_unexpected", 1, 0);
          else begin
            t = tick_q.pop_front();
            chk("tick_idx", int'(stepIdxO), t);
          end
        end
      end
    end
    chk("exp_left", exp_q.size(), 0);
    chk("tick_left", tick_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
